multicycle_controller: RTL and testbench

- Moore-style FSM that sequences a multi-cycle RV32I datapath: shared instruction/data memory, single ALU, IR/ALUOut/data registers.
- Follow-on to the single-cycle main decoder. Decodes the same opcode set: R-type, load, store, branch.
- Adds a memory ready handshake, a retired-instruction counter and a sticky illegal-opcode trap.

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller side is the master; the datapath side is the slave.
interface multicycle_controller_if #(
   parameter int unsigned RETIRE_W = 32
);
   logic [6:0]          opcode;
   logic                zero;
   logic                mem_ready;
   logic                pc_write;
   logic                ir_write;
   logic                adr_src;
   logic                mem_read;
   logic                mem_write;
   logic                reg_write;
   logic [1:0]          result_src;
   logic [1:0]          alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic [3:0]          state;
   logic                illegal;
   logic [RETIRE_W-1:0] retired;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, state, illegal, retired
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, state, illegal, retired
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multi-cycle RV32I datapath (R-type, load, store, beq),
// with memory ready handshake, retired-instruction counter and sticky illegal trap.
module multicycle_controller #(
   parameter int unsigned RETIRE_W = 32
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_controller_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8,
      S_TRAP     = 4'd9
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   state_e              state_q, state_d;
   logic                store_q;
   logic                illegal_q;
   logic [RETIRE_W-1:0] retired_q;
   logic                retire;

   logic       adr_src_q, mem_read_q, mem_write_q, reg_write_q;
   logic       adr_src_d, mem_read_d, mem_write_d, reg_write_d;
   logic [1:0] result_src_q, alu_src_a_q, alu_src_b_q, alu_op_q;
   logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, alu_op_d;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      unique case (state_q)
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_BEQ:            state_d = S_BEQ;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = store_q ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWRITE: begin
            if (bus.mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECR:    state_d = S_ALUWB;
         S_ALUWB, S_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore outputs are decoded from the next state so they can be registered
   // and still line up with the state they belong to.
   always_comb begin
      adr_src_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
      alu_src_a_d  = 2'b00;
      alu_src_b_d  = 2'b00;
      alu_op_d     = 2'b00;
      case (state_d)
         S_FETCH: begin
            mem_read_d   = 1'b1;
            result_src_d = 2'b10;
            alu_src_b_d  = 2'b10;
         end
         S_DECODE: begin
            alu_src_a_d = 2'b01;
            alu_src_b_d = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a_d = 2'b10;
            alu_src_b_d = 2'b01;
         end
         S_MEMREAD: begin
            mem_read_d = 1'b1;
            adr_src_d  = 1'b1;
         end
         S_MEMWB: begin
            result_src_d = 2'b01;
            reg_write_d  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_write_d = 1'b1;
            adr_src_d   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a_d = 2'b10;
            alu_op_d    = 2'b10;
         end
         S_ALUWB:    reg_write_d = 1'b1;
         S_BEQ: begin
            alu_src_a_d = 2'b10;
            alu_op_d    = 2'b01;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         store_q      <= 1'b0;
         illegal_q    <= 1'b0;
         retired_q    <= '0;
         adr_src_q    <= 1'b0;
         mem_read_q   <= 1'b1;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         result_src_q <= 2'b10;
         alu_src_a_q  <= 2'b00;
         alu_src_b_q  <= 2'b10;
         alu_op_q     <= 2'b00;
      end else begin
         state_q      <= state_d;
         adr_src_q    <= adr_src_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         alu_src_a_q  <= alu_src_a_d;
         alu_src_b_q  <= alu_src_b_d;
         alu_op_q     <= alu_op_d;
         if (state_q == S_DECODE) store_q <= (bus.opcode == OP_STORE);
         if (state_d == S_TRAP)   illegal_q <= 1'b1;
         if (retire)              retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   // ir_write/pc_write follow mem_ready and zero within the cycle.
   assign bus.ir_write   = (state_q == S_FETCH) && bus.mem_ready;
   assign bus.pc_write   = ((state_q == S_FETCH) && bus.mem_ready) ||
                           ((state_q == S_BEQ) && bus.zero);
   assign bus.adr_src    = adr_src_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.reg_write  = reg_write_q;
   assign bus.result_src = result_src_q;
   assign bus.alu_src_a  = alu_src_a_q;
   assign bus.alu_src_b  = alu_src_b_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.state      = state_q;
   assign bus.illegal    = illegal_q;
   assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_multicycle_controller;
   localparam int unsigned RW = 32;

   // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
   //  result_src, alu_src_a, alu_src_b, alu_op}
   localparam logic [13:0] C_F0  = 14'b00_0100_10_00_10_00;
   localparam logic [13:0] C_F1  = 14'b11_0100_10_00_10_00;
   localparam logic [13:0] C_DEC = 14'b00_0000_00_01_01_00;
   localparam logic [13:0] C_MA  = 14'b00_0000_00_10_01_00;
   localparam logic [13:0] C_MR  = 14'b00_1100_00_00_00_00;
   localparam logic [13:0] C_MWB = 14'b00_0001_01_00_00_00;
   localparam logic [13:0] C_MW  = 14'b00_1010_00_00_00_00;
   localparam logic [13:0] C_EX  = 14'b00_0000_00_10_00_10;
   localparam logic [13:0] C_AWB = 14'b00_0001_00_00_00_00;
   localparam logic [13:0] C_BQ0 = 14'b00_0000_00_10_00_01;
   localparam logic [13:0] C_BQ1 = 14'b10_0000_00_10_00_01;
   localparam logic [13:0] C_TRP = 14'b00_0000_00_00_00_00;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] RT = 7'b0110011;
   localparam logic [6:0] BQ = 7'b1100011;
   localparam logic [6:0] XX = 7'b1111111;

   typedef struct packed {
      logic [3:0]    st;
      logic [13:0]   ctrl;
      logic          ill;
      logic [RW-1:0] ret;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   multicycle_controller_if #(.RETIRE_W(RW)) bus ();
   multicycle_controller #(.RETIRE_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic step(input logic [6:0] op, input logic z, input logic rdy,
                       input logic rst, input logic [3:0] st,
                       input logic [13:0] c, input logic ill,
                       input logic [RW-1:0] ret);
      exp_t e;
      @(posedge clk);
      #1;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      reset         = rst;
      e.st = st; e.ctrl = c; e.ill = ill; e.ret = ret;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [13:0] act;
         e = sb.pop_front();
         act = {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.result_src, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op};
         total++;
         if (bus.state !== e.st) begin
            bad++;
            $display("FAIL state t=%0t got=%0d want=%0d", $time, bus.state, e.st);
         end
         total++;
         if (act !== e.ctrl) begin
            bad++;
            $display("FAIL ctrl t=%0t state=%0d got=%b want=%b", $time, bus.state, act, e.ctrl);
         end
         total++;
         if (bus.illegal !== e.ill) begin
            bad++;
            $display("FAIL illegal t=%0t got=%b want=%b", $time, bus.illegal, e.ill);
         end
         total++;
         if (bus.retired !== e.ret) begin
            bad++;
            $display("FAIL retired t=%0t got=%0d want=%0d", $time, bus.retired, e.ret);
         end
      end
   end

   initial begin
      bus.opcode    = 7'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      // R-type: 0,1,6,7,0
      step(RT, 0, 1, 0, 4'd0, C_F1,  0, 0);
      step(RT, 0, 0, 0, 4'd1, C_DEC, 0, 0);
      step(RT, 0, 0, 0, 4'd6, C_EX,  0, 0);
      step(RT, 0, 1, 0, 4'd7, C_AWB, 0, 0);
      step(LD, 0, 1, 0, 4'd0, C_F1,  0, 1);
      // Load, two wait cycles; opcode changed after DECODE must not matter
      step(LD, 0, 1, 0, 4'd1, C_DEC, 0, 1);
      step(ST, 0, 1, 0, 4'd2, C_MA,  0, 1);
      step(ST, 0, 0, 0, 4'd3, C_MR,  0, 1);
      step(ST, 0, 0, 0, 4'd3, C_MR,  0, 1);
      step(ST, 0, 1, 0, 4'd3, C_MR,  0, 1);
      step(ST, 0, 0, 0, 4'd4, C_MWB, 0, 1);
      step(ST, 0, 1, 0, 4'd0, C_F1,  0, 2);
      // Store
      step(ST, 0, 0, 0, 4'd1, C_DEC, 0, 2);
      step(LD, 0, 1, 0, 4'd2, C_MA,  0, 2);
      step(LD, 0, 1, 0, 4'd5, C_MW,  0, 2);
      step(BQ, 0, 1, 0, 4'd0, C_F1,  0, 3);
      // Branch taken then not taken
      step(BQ, 0, 0, 0, 4'd1, C_DEC, 0, 3);
      step(BQ, 1, 0, 0, 4'd8, C_BQ1, 0, 3);
      step(BQ, 0, 1, 0, 4'd0, C_F1,  0, 4);
      step(BQ, 1, 0, 0, 4'd1, C_DEC, 0, 4);
      step(BQ, 0, 1, 0, 4'd8, C_BQ0, 0, 4);
      // Fetch stall
      step(XX, 0, 0, 0, 4'd0, C_F0,  0, 5);
      step(XX, 0, 0, 0, 4'd0, C_F0,  0, 5);
      step(XX, 0, 0, 0, 4'd0, C_F0,  0, 5);
      step(XX, 0, 1, 0, 4'd0, C_F1,  0, 5);
      // Illegal opcode traps and sticks
      step(XX, 0, 1, 0, 4'd1, C_DEC, 0, 5);
      for (int i = 0; i < 10; i++)
         step(RT, 1'(i), 1'(i >> 1), 0, 4'd9, C_TRP, 1, 5);
      step(RT, 0, 1, 1, 4'd9, C_TRP, 1, 5);
      step(ST, 0, 0, 0, 4'd0, C_F0,  0, 0);
      // Reset during a MEMWRITE wait, reset beats mem_ready
      step(ST, 0, 1, 0, 4'd0, C_F1,  0, 0);
      step(ST, 0, 0, 0, 4'd1, C_DEC, 0, 0);
      step(ST, 0, 0, 0, 4'd2, C_MA,  0, 0);
      step(ST, 0, 0, 0, 4'd5, C_MW,  0, 0);
      step(ST, 0, 0, 0, 4'd5, C_MW,  0, 0);
      step(ST, 0, 1, 1, 4'd5, C_MW,  0, 0);
      step(ST, 0, 0, 0, 4'd0, C_F0,  0, 0);
      step(ST, 0, 0, 0, 4'd0, C_F0,  0, 0);
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
